// File: rtl/picorv32_soc_pkg.sv
// SoC-wide constants: crossbar address map and interrupt-controller register layout.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package picorv32_soc_pkg;

    // Interrupt controller register byte offsets; only bits [4:2] are decoded.
    localparam logic [4:0] IRQC_PENDING_OFF = 5'h00;
    localparam logic [4:0] IRQC_ENABLE_OFF  = 5'h04;
    localparam logic [4:0] IRQC_EDGE_OFF    = 5'h08;
    localparam logic [4:0] IRQC_ACTIVE_OFF  = 5'h0C;
    localparam logic [4:0] IRQC_SWTRIG_OFF  = 5'h10;
    localparam logic [4:0] IRQC_CLAIM_OFF   = 5'h14;

    localparam logic [1:0] IRQC_RESP_OKAY   = 2'b00;
    localparam logic [1:0] IRQC_RESP_SLVERR = 2'b10;

    // First PicoRV32 irq line driven by the controller (0..2 are CPU-internal).
    localparam int IRQC_IRQ_BASE_p = 3;

    // CLAIM value returned when nothing is active.
    localparam logic [5:0] IRQC_CLAIM_NONE = 6'd32;

    // Per-channel AXI-Lite slave handshake state.
    typedef enum logic [1:0] {
        AXI_IDLE = 2'd0,
        AXI_ACC  = 2'd1,
        AXI_RESP = 2'd2
    } irqc_axi_st_e;

    // Crossbar address map: a slot hits when (addr & mask) == base.
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
    } soc_addr_rule_t;

    localparam int SOC_SLOT_ROM  = 0;
    localparam int SOC_SLOT_RAM  = 1;
    localparam int SOC_SLOT_UART = 2;
    localparam int SOC_SLOT_IRQC = 3;
    localparam int SOC_SLOT_NBR  = 4;

    localparam soc_addr_rule_t SOC_ADDR_MAP [SOC_SLOT_NBR] = '{
        '{base: 32'h0000_0000, mask: 32'hFFFF_0000},
        '{base: 32'h1000_0000, mask: 32'hFFFF_0000},
        '{base: 32'h2000_0000, mask: 32'hFFFF_F000},
        '{base: 32'h2000_1000, mask: 32'hFFFF_F000}
    };

    function automatic logic soc_addr_hit(input logic [31:0] addr, input int slot);
        soc_addr_hit = ((addr & SOC_ADDR_MAP[slot].mask) == SOC_ADDR_MAP[slot].base);
    endfunction

    // Lowest set index of a 32-bit vector, or 32 when empty.
    function automatic logic [5:0] irqc_claim(input logic [31:0] act);
        irqc_claim = IRQC_CLAIM_NONE;
        for (int i = 31; i >= 0; i--) begin
            if (act[i]) begin
                irqc_claim = 6'(i);
            end
        end
    endfunction

endpackage

// File: rtl/irq_ctrl_src.sv
// One interrupt source: edge/level detect, pending flop, registered CPU irq line.
// Latency: source sampled at N -> pending at N+1 -> o_irq at N+2.
// Backpressure: none; every cycle is sampled, set beats clear.
module irq_ctrl_src
    import picorv32_soc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_src,
    input  logic i_eoi,
    input  logic i_enable,
    input  logic i_edge,
    input  logic i_sw_set,
    input  logic i_w1c,
    output logic o_pending,
    output logic o_irq
);

    logic r_src_prev;
    logic r_eoi_prev;
    logic r_pending;
    logic r_irq;
    logic w_set;
    logic w_clr;

    // Set/clear requests; end-of-interrupt only retires edge-mode events,
    // a level source keeps re-pending for as long as it is held.
    always_comb begin
        w_set = i_sw_set | (i_edge ? (i_src & ~r_src_prev) : i_src);
        w_clr = i_w1c | (i_edge & i_eoi & ~r_eoi_prev);
    end

    // Pending state, history samples and the masked-while-in-service irq line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_prev <= 1'b0;
            r_eoi_prev <= 1'b0;
            r_pending  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_src_prev <= i_src;
            r_eoi_prev <= i_eoi;
            if (w_set) begin
                r_pending <= 1'b1;
            end else if (w_clr) begin
                r_pending <= 1'b0;
            end
            r_irq <= r_pending & i_enable & ~i_eoi;
        end
    end

    assign o_pending = r_pending;
    assign o_irq     = r_irq;

endmodule

// File: rtl/axi_irq_ctrl.sv
// AXI4-Lite interrupt controller: pending/enable/edge registers, claim encoder, per-source irq lines.
// Latency: write commits and bvalid at A+1; read data sampled at R, rvalid at R+1; irq 2 cycles after source.
// Backpressure: no new AW/W or AR accepted while a B or R response is held waiting for bready/rready.
module axi_irq_ctrl
    import picorv32_soc_pkg::*;
#(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int IRQ_NBR_p     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    output logic                     o_axi_awready,
    input  logic [31:0]              i_axi_wdata,
    input  logic [3:0]               i_axi_wstrb,
    input  logic                     i_axi_wvalid,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic                     i_axi_rready,
    input  logic [IRQ_NBR_p-1:0]     i_irq_src,
    input  logic [IRQ_NBR_p-1:0]     i_eoi,
    output logic [IRQ_NBR_p-1:0]     o_irq
);

    localparam logic [2:0] L_PENDING = IRQC_PENDING_OFF[4:2];
    localparam logic [2:0] L_ENABLE  = IRQC_ENABLE_OFF[4:2];
    localparam logic [2:0] L_EDGE    = IRQC_EDGE_OFF[4:2];
    localparam logic [2:0] L_ACTIVE  = IRQC_ACTIVE_OFF[4:2];
    localparam logic [2:0] L_SWTRIG  = IRQC_SWTRIG_OFF[4:2];
    localparam logic [2:0] L_CLAIM   = IRQC_CLAIM_OFF[4:2];

    irqc_axi_st_e r_wr_st;
    irqc_axi_st_e w_wr_st_nxt;
    irqc_axi_st_e r_rd_st;
    irqc_axi_st_e w_rd_st_nxt;

    logic [1:0]           r_bresp;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;
    logic [IRQ_NBR_p-1:0] r_enable;
    logic [IRQ_NBR_p-1:0] r_edge;

    logic                 w_wr_commit;
    logic                 w_rd_take;
    logic [2:0]           w_wr_idx;
    logic [2:0]           w_rd_idx;
    logic                 w_wr_mapped;
    logic [31:0]          w_strb_mask;
    logic [31:0]          w_wdat_m;
    logic [IRQ_NBR_p-1:0] w_w1c;
    logic [IRQ_NBR_p-1:0] w_sw_set;
    logic [IRQ_NBR_p-1:0] w_enable_nxt;
    logic [IRQ_NBR_p-1:0] w_edge_nxt;
    logic [IRQ_NBR_p-1:0] w_pending;
    logic [IRQ_NBR_p-1:0] w_active;
    logic [31:0]          w_active32;
    logic [5:0]           w_claim;
    logic [31:0]          w_rd_dat;
    logic [1:0]           w_rd_resp;
    logic                 w_unused_sink;

    assign w_wr_idx    = i_axi_awaddr[4:2];
    assign w_rd_idx    = i_axi_araddr[4:2];
    assign w_wr_commit = (r_wr_st == AXI_ACC) & i_axi_awvalid & i_axi_wvalid;
    assign w_rd_take   = (r_rd_st == AXI_ACC) & i_axi_arvalid;

    // Write channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_st <= AXI_IDLE;
        end else begin
            r_wr_st <= w_wr_st_nxt;
        end
    end

    // Write channel next state: accept only when address and data are both offered.
    always_comb begin
        w_wr_st_nxt = r_wr_st;
        case (r_wr_st)
            AXI_IDLE: if (i_axi_awvalid & i_axi_wvalid) w_wr_st_nxt = AXI_ACC;
            AXI_ACC:  if (w_wr_commit)                  w_wr_st_nxt = AXI_RESP;
            AXI_RESP: if (i_axi_bready)                 w_wr_st_nxt = AXI_IDLE;
            default:                                    w_wr_st_nxt = AXI_IDLE;
        endcase
    end

    // Read channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_st <= AXI_IDLE;
        end else begin
            r_rd_st <= w_rd_st_nxt;
        end
    end

    // Read channel next state.
    always_comb begin
        w_rd_st_nxt = r_rd_st;
        case (r_rd_st)
            AXI_IDLE: if (i_axi_arvalid) w_rd_st_nxt = AXI_ACC;
            AXI_ACC:  if (w_rd_take)     w_rd_st_nxt = AXI_RESP;
            AXI_RESP: if (i_axi_rready)  w_rd_st_nxt = AXI_IDLE;
            default:                     w_rd_st_nxt = AXI_IDLE;
        endcase
    end

    // Write decode: byte-lane masking, W1C/SWTRIG strobes and ENABLE/EDGE next values.
    always_comb begin
        w_strb_mask  = {{8{i_axi_wstrb[3]}}, {8{i_axi_wstrb[2]}},
                        {8{i_axi_wstrb[1]}}, {8{i_axi_wstrb[0]}}};
        w_wdat_m     = i_axi_wdata & w_strb_mask;
        w_wr_mapped  = (w_wr_idx <= L_CLAIM);
        w_w1c        = '0;
        w_sw_set     = '0;
        w_enable_nxt = r_enable;
        w_edge_nxt   = r_edge;
        if (w_wr_commit) begin
            case (w_wr_idx)
                L_PENDING: w_w1c        = w_wdat_m[IRQ_NBR_p-1:0];
                L_ENABLE:  w_enable_nxt = (r_enable & ~w_strb_mask[IRQ_NBR_p-1:0])
                                          | w_wdat_m[IRQ_NBR_p-1:0];
                L_EDGE:    w_edge_nxt   = (r_edge & ~w_strb_mask[IRQ_NBR_p-1:0])
                                          | w_wdat_m[IRQ_NBR_p-1:0];
                L_SWTRIG:  w_sw_set     = w_wdat_m[IRQ_NBR_p-1:0];
                default:   ;
            endcase
        end
    end

    // ENABLE/EDGE storage and the write response code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= '0;
            r_edge   <= '0;
            r_bresp  <= IRQC_RESP_OKAY;
        end else begin
            r_enable <= w_enable_nxt;
            r_edge   <= w_edge_nxt;
            if (w_wr_commit) begin
                r_bresp <= w_wr_mapped ? IRQC_RESP_OKAY : IRQC_RESP_SLVERR;
            end
        end
    end

    // Per-source pending/irq logic.
    for (genvar g = 0; g < IRQ_NBR_p; g++) begin : g_src
        irq_ctrl_src u_src (
            .clk       (clk),
            .rst       (rst),
            .i_src     (i_irq_src[g]),
            .i_eoi     (i_eoi[g]),
            .i_enable  (r_enable[g]),
            .i_edge    (r_edge[g]),
            .i_sw_set  (w_sw_set[g]),
            .i_w1c     (w_w1c[g]),
            .o_pending (w_pending[g]),
            .o_irq     (o_irq[g])
        );
    end

    // ACTIVE vector widened to 32 bits for the claim priority encoder.
    always_comb begin
        w_active                    = w_pending & r_enable;
        w_active32                  = '0;
        w_active32[IRQ_NBR_p-1:0]   = w_active;
        w_claim                     = irqc_claim(w_active32);
    end

    // Read mux; unmapped offsets return zero with SLVERR.
    always_comb begin
        w_rd_dat  = '0;
        w_rd_resp = IRQC_RESP_OKAY;
        case (w_rd_idx)
            L_PENDING: w_rd_dat[IRQ_NBR_p-1:0] = w_pending;
            L_ENABLE:  w_rd_dat[IRQ_NBR_p-1:0] = r_enable;
            L_EDGE:    w_rd_dat[IRQ_NBR_p-1:0] = r_edge;
            L_ACTIVE:  w_rd_dat                = w_active32;
            L_SWTRIG:  w_rd_dat                = '0;
            L_CLAIM:   w_rd_dat                = 32'(w_claim);
            default:   w_rd_resp               = IRQC_RESP_SLVERR;
        endcase
    end

    // Read data is captured in the accept cycle and held until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= IRQC_RESP_OKAY;
        end else if (w_rd_take) begin
            r_rdata <= w_rd_dat;
            r_rresp <= w_rd_resp;
        end
    end

    assign o_axi_awready = (r_wr_st == AXI_ACC);
    assign o_axi_wready  = (r_wr_st == AXI_ACC);
    assign o_axi_bvalid  = (r_wr_st == AXI_RESP);
    assign o_axi_bresp   = r_bresp;
    assign o_axi_arready = (r_rd_st == AXI_ACC);
    assign o_axi_rvalid  = (r_rd_st == AXI_RESP);
    assign o_axi_rdata   = r_rdata;
    assign o_axi_rresp   = r_rresp;

    // Address bits above [4:2] and data bits above the source count are don't-care.
    assign w_unused_sink = ^{i_axi_awaddr, i_axi_araddr, i_axi_wdata, w_strb_mask, w_wdat_m};

endmodule
